// File: rtl/tilt_direction_decoder.sv
// tilt_direction_decoder
//   Turns raw signed accelerometer samples into one-hot move requests for the
//   ball block. Samples are box-averaged over 2^AVG_LOG2 samples. Each average
//   is classified into one of five directions: none, +X, -X, +Y or -Y. A
//   deadzone with hysteresis applies, and the dominant axis wins, with ties
//   going to X. A new direction must repeat for HOLD_SAMPLES consecutive
//   averages before the outputs switch to it.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   accel_x      signed X tilt sample, valid with accel_valid
//   accel_y      signed Y tilt sample, valid with accel_valid
//   accel_valid  one-cycle strobe per sample, any rate including back-to-back
//   x_increment  registered, X tilt positive
//   x_decrement  registered, X tilt negative
//   y_increment  registered, Y tilt positive
//   y_decrement  registered, Y tilt negative
module tilt_direction_decoder #(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned AVG_LOG2     = 2,
  parameter int unsigned DEADZONE     = 64,
  parameter int unsigned HYST         = 16,
  parameter int unsigned HOLD_SAMPLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] accel_x,
  input  logic [DATA_WIDTH-1:0] accel_y,
  input  logic                  accel_valid,
  output logic                  x_increment,
  output logic                  x_decrement,
  output logic                  y_increment,
  output logic                  y_decrement
);

  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned ACC_W  = DATA_WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_SAMPLES + 1);

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_XP   = 3'd1,
    DIR_XN   = 3'd2,
    DIR_YP   = 3'd3,
    DIR_YN   = 3'd4
  } dir_e;

  // Averaging stage
  logic signed [ACC_W-1:0] r_acc_x;
  logic signed [ACC_W-1:0] r_acc_y;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [DW-1:0]    r_avg_x;
  logic signed [DW-1:0]    r_avg_y;
  logic                    r_avg_vld;

  // Classification and debounce stages
  dir_e                    r_cand;
  logic                    r_cand_vld;
  dir_e                    r_pend;
  logic [HOLD_W-1:0]       r_hold_cnt;
  dir_e                    r_out_dir;

  logic signed [ACC_W-1:0] w_sum_x;
  logic signed [ACC_W-1:0] w_sum_y;
  logic signed [DW-1:0]    w_avg_x;
  logic signed [DW-1:0]    w_avg_y;
  logic                    w_win_done;

  logic [DW-1:0]           w_mag_x;
  logic [DW-1:0]           w_mag_y;
  logic [DW-1:0]           w_dom_mag;
  logic [DW-1:0]           w_thresh;
  dir_e                    w_dir_raw;
  dir_e                    w_cand;

  dir_e                    w_pend_nxt;
  logic [HOLD_W-1:0]       w_cnt_nxt;
  logic                    w_load;

  // |v| with the most negative code saturated to the largest positive one
  function automatic logic [DW-1:0] f_mag(input logic signed [DW-1:0] v);
    logic [DW-1:0] m;
    if (v == $signed({1'b1, {(DW-1){1'b0}}})) begin
      m = {1'b0, {(DW-1){1'b1}}};
    end else if (v[DW-1]) begin
      m = DW'(-v);
    end else begin
      m = DW'(v);
    end
    return m;
  endfunction

  // Running sums include the current sample so the completing sample is counted
  assign w_sum_x    = r_acc_x + ACC_W'($signed(accel_x));
  assign w_sum_y    = r_acc_y + ACC_W'($signed(accel_y));
  assign w_avg_x    = DW'(w_sum_x >>> AVG_LOG2);
  assign w_avg_y    = DW'(w_sum_y >>> AVG_LOG2);
  assign w_win_done = accel_valid && (r_cnt == CNT_W'((1 << AVG_LOG2) - 1));

  // Classify the latched average; hysteresis favours the currently driven direction
  always_comb begin
    w_mag_x   = f_mag(r_avg_x);
    w_mag_y   = f_mag(r_avg_y);
    w_dom_mag = w_mag_x;
    w_dir_raw = DIR_NONE;
    w_thresh  = DW'(DEADZONE);
    w_cand    = DIR_NONE;

    if (w_mag_x >= w_mag_y) begin
      w_dom_mag = w_mag_x;
      w_dir_raw = r_avg_x[DW-1] ? DIR_XN : DIR_XP;
    end else begin
      w_dom_mag = w_mag_y;
      w_dir_raw = r_avg_y[DW-1] ? DIR_YN : DIR_YP;
    end

    if (w_dir_raw == r_out_dir) begin
      w_thresh = DW'(DEADZONE - HYST);
    end

    if (w_dom_mag >= w_thresh) begin
      w_cand = w_dir_raw;
    end
  end

  // Debounce: count consecutive equal candidates, saturating at HOLD_SAMPLES
  always_comb begin
    w_pend_nxt = r_pend;
    w_cnt_nxt  = r_hold_cnt;
    if (r_cand == r_pend) begin
      if (r_hold_cnt >= HOLD_W'(HOLD_SAMPLES)) begin
        w_cnt_nxt = HOLD_W'(HOLD_SAMPLES);
      end else begin
        w_cnt_nxt = r_hold_cnt + HOLD_W'(1);
      end
    end else begin
      w_pend_nxt = r_cand;
      w_cnt_nxt  = HOLD_W'(1);
    end
    w_load = r_cand_vld && (w_cnt_nxt == HOLD_W'(HOLD_SAMPLES));
  end

  // Pipeline: window done -> avg latched; +1 -> candidate; +2 -> debounce/outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_x     <= '0;
      r_acc_y     <= '0;
      r_cnt       <= '0;
      r_avg_x     <= '0;
      r_avg_y     <= '0;
      r_avg_vld   <= 1'b0;
      r_cand      <= DIR_NONE;
      r_cand_vld  <= 1'b0;
      r_pend      <= DIR_NONE;
      r_hold_cnt  <= '0;
      r_out_dir   <= DIR_NONE;
      x_increment <= 1'b0;
      x_decrement <= 1'b0;
      y_increment <= 1'b0;
      y_decrement <= 1'b0;
    end else begin
      r_avg_vld <= w_win_done;
      if (accel_valid) begin
        if (w_win_done) begin
          r_acc_x <= '0;
          r_acc_y <= '0;
          r_cnt   <= '0;
          r_avg_x <= w_avg_x;
          r_avg_y <= w_avg_y;
        end else begin
          r_acc_x <= w_sum_x;
          r_acc_y <= w_sum_y;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
      end

      r_cand_vld <= r_avg_vld;
      if (r_avg_vld) begin
        r_cand <= w_cand;
      end

      if (r_cand_vld) begin
        r_pend     <= w_pend_nxt;
        r_hold_cnt <= w_cnt_nxt;
      end

      // All four outputs reload together so they never overlap
      if (w_load) begin
        r_out_dir   <= w_pend_nxt;
        x_increment <= (w_pend_nxt == DIR_XP);
        x_decrement <= (w_pend_nxt == DIR_XN);
        y_increment <= (w_pend_nxt == DIR_YP);
        y_decrement <= (w_pend_nxt == DIR_YN);
      end
    end
  end

endmodule

// File: tb/tb_tilt_direction_decoder.sv
// tb_tilt_direction_decoder
//   Directed scenarios followed by randomized bursts, every cycle compared
//   against an integer-arithmetic reference model of the decoder.
module tb_tilt_direction_decoder;

  localparam int unsigned HOLD = 2;

  logic        clk;
  logic        reset;
  logic [11:0] accel_x;
  logic [11:0] accel_y;
  logic        accel_valid;
  logic        x_increment;
  logic        x_decrement;
  logic        y_increment;
  logic        y_decrement;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: 0 none, 1 +X, 2 -X, 3 +Y, 4 -Y
  int m_sum_x, m_sum_y, m_n;
  int m_pend, m_cnt;
  int m_out, m_sched, m_delay;

  tilt_direction_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .accel_x     (accel_x),
    .accel_y     (accel_y),
    .accel_valid (accel_valid),
    .x_increment (x_increment),
    .x_decrement (x_decrement),
    .y_increment (y_increment),
    .y_decrement (y_decrement)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] dir_bits(input int d);
    case (d)
      1:       return 4'b1000;
      2:       return 4'b0100;
      3:       return 4'b0010;
      4:       return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int floor4(input int s);
    if (s >= 0) return s / 4;
    else        return -((-s + 3) / 4);
  endfunction

  function automatic int mag_of(input int a);
    if (a == -2048) return 2047;
    return (a < 0) ? -a : a;
  endfunction

  function automatic int clamp12(input int v);
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int classify(input int ax, input int ay, input int cur);
    int mx, my, md, d, thr;
    mx = mag_of(ax);
    my = mag_of(ay);
    if (mx >= my) begin
      md = mx;
      d  = (ax >= 0) ? 1 : 2;
    end else begin
      md = my;
      d  = (ay >= 0) ? 3 : 4;
    end
    thr = (d == cur) ? 48 : 64;
    return (md < thr) ? 0 : d;
  endfunction

  task automatic model_reset();
    m_sum_x = 0; m_sum_y = 0; m_n = 0;
    m_pend = 0; m_cnt = 0;
    m_out = 0; m_sched = 0; m_delay = 0;
  endtask

  // One clock edge of the reference: a finished window becomes visible two edges later
  task automatic model_edge(input logic rst, input logic v, input int x, input int y);
    int c;
    if (rst) begin
      model_reset();
    end else begin
      if (m_delay > 0) begin
        m_delay--;
        if (m_delay == 0) m_out = m_sched;
      end
      if (v) begin
        m_sum_x += x;
        m_sum_y += y;
        m_n++;
        if (m_n == 4) begin
          c = classify(floor4(m_sum_x), floor4(m_sum_y), m_out);
          if (c == m_pend) begin
            if (m_cnt < HOLD) m_cnt++;
          end else begin
            m_pend = c;
            m_cnt  = 1;
          end
          if (m_cnt == HOLD) begin
            m_sched = m_pend;
            m_delay = 2;
          end
          m_sum_x = 0; m_sum_y = 0; m_n = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: outputs {xi,xd,yi,yd} observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {x_increment, x_decrement, y_increment, y_decrement};
  endfunction

  // Drive one cycle, advance the model on the same edge, compare just after it
  task automatic step(input logic rst, input logic v, input int x, input int y, input string tag);
    int xs, ys;
    xs = clamp12(x);
    ys = clamp12(y);
    reset       = rst;
    accel_valid = v;
    accel_x     = 12'(xs);
    accel_y     = 12'(ys);
    @(posedge clk);
    model_edge(rst, v, xs, ys);
    #1;
    check(tag, outs(), dir_bits(m_out));
  endtask

  task automatic feed(input int n, input int x, input int y, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, x, y, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, tag);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, "reset");
    step(1'b0, 1'b0, 0, 0, "reset_release");
  endtask

  int bx, by, r;
  logic rv, rr;

  initial begin
    reset = 1'b1; accel_valid = 1'b0; accel_x = '0; accel_y = '0;
    model_reset();

    // Reset held with samples arriving: outputs stay quiet
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 300, -300, "reset_with_valid");
      check("reset_zero", outs(), 4'b0000);
    end
    step(1'b0, 1'b0, 0, 0, "after_release");
    check("after_release_zero", outs(), 4'b0000);

    // Strong +X: change exactly two cycles after the 8th sample
    feed(4, 200, 0, "xp_first_window");
    check("xp_after_4", outs(), 4'b0000);
    feed(4, 200, 0, "xp_second_window");
    check("xp_at_8th", outs(), 4'b0000);
    idle(1, "xp_lat1");
    check("xp_lat1", outs(), 4'b0000);
    idle(1, "xp_lat2");
    check("xp_lat2", outs(), 4'b1000);

    // Deadzone, then saturated most-negative X
    do_reset(1);
    feed(8, 60, -63, "deadzone");
    idle(3, "deadzone_idle");
    check("deadzone_none", outs(), 4'b0000);
    feed(8, -2048, 0, "sat_neg");
    idle(2, "sat_neg_idle");
    check("sat_neg_xd", outs(), 4'b0100);

    // Hysteresis keeps +X at 50, releases at 40
    do_reset(1);
    feed(8, 200, 0, "hyst_set");
    idle(2, "hyst_set_idle");
    check("hyst_set", outs(), 4'b1000);
    feed(8, 50, 0, "hyst_hold");
    idle(2, "hyst_hold_idle");
    check("hyst_hold", outs(), 4'b1000);
    feed(4, 40, 0, "hyst_drop1");
    idle(2, "hyst_drop1_idle");
    check("hyst_drop_one_window", outs(), 4'b1000);
    feed(4, 40, 0, "hyst_drop2");
    idle(2, "hyst_drop2_idle");
    check("hyst_drop", outs(), 4'b0000);

    // Tie goes to X; alternating windows do not switch; steady -Y does
    do_reset(1);
    feed(8, 100, -100, "tie");
    idle(2, "tie_idle");
    check("tie_x", outs(), 4'b1000);
    feed(4, 100, -300, "bounce_y");
    feed(4, 200, 0, "bounce_x");
    idle(2, "bounce_idle");
    check("debounce_hold", outs(), 4'b1000);
    feed(8, 0, -300, "steady_yn");
    idle(2, "steady_yn_idle");
    check("steady_yn", outs(), 4'b0001);

    // Reset mid-window discards the partial +X samples
    do_reset(1);
    feed(2, 200, 0, "partial");
    do_reset(1);
    feed(8, -200, 0, "after_partial");
    idle(2, "after_partial_idle");
    check("partial_discard", outs(), 4'b0100);

    // Averages round toward minus infinity
    do_reset(1);
    feed(1, -1, 0, "floor_a"); feed(1, -1, 0, "floor_a");
    feed(1, -2, 0, "floor_a"); feed(1, -3, 0, "floor_a");
    idle(3, "floor_a_idle");
    for (int k = 0; k < 2; k++) begin
      feed(3, -64, 0, "floor_neg"); feed(1, -63, 0, "floor_neg");
    end
    idle(2, "floor_neg_idle");
    check("floor_neg_reaches_64", outs(), 4'b0100);
    do_reset(1);
    for (int k = 0; k < 2; k++) begin
      feed(3, 64, 0, "floor_pos"); feed(1, 63, 0, "floor_pos");
    end
    idle(2, "floor_pos_idle");
    check("floor_pos_below_64", outs(), 4'b0000);

    // Randomized bursts around a drifting tilt, with sparse valids and resets
    do_reset(1);
    bx = 0; by = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 24 == 0) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      bx = -2048;
        else if (r == 1) bx = 2047;
        else             bx = int'($urandom_range(0, 500)) - 250;
        by = int'($urandom_range(0, 500)) - 250;
      end
      rr = ($urandom_range(0, 199) == 0);
      rv = ($urandom_range(0, 3) != 0);
      step(rr, rv, bx + int'($urandom_range(0, 120)) - 60,
           by + int'($urandom_range(0, 120)) - 60, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
